keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Behavioural 4x4 matrix keypad model implemented in synthesizable RTL: it answers the keypad column scan with row responses exactly as a physical keypad would, for key presses requested through a valid/ready command port. It is the responder end of the keypad column/row interface. It sits between a test driver (or on-board self-test logic) and the scanner's `colPins`/`rowPins`. This allows closed-loop scanner, debounce and display verification without hardware. Presses are queued, optionally bounced, held, released, and separated by a quiet gap.

## Interface
- `HOLD_CYCLES`, default 2000: cycles the contact is solidly closed per press (>=1).
- `GAP_CYCLES`, default 2000: cycles of forced release after each press (>=1).
- `BOUNCE_CYCLES`, default 64: length of one bounce period, in cycles (>=1).
- `BOUNCE_TOGGLES`, default 4: bounce period pairs on make and on break; 0 disables bounce.
- `QUEUE_DEPTH`, default 4: key command FIFO depth (power of two, >=2).
- `clk` in, 1: system clock.
- `reset` in, 1: asynchronous, active-high reset.
- `keyValid` in, 1: key command valid.
- `keyCode` in, 4: physical key position. Row = `keyCode[3:2]`, column = `keyCode[1:0]`.
- `keyReady` out, 1: FIFO can accept a command (not full).
- `colPins` in, 4: scanner column drive, active-low.
- `rowPins` out, 4: row response, active-low; idle all ones.
- `busy` out, 1: FIFO non-empty or FSM not in IDLE.
- `pressCount` out, 8: number of presses that have reached HOLD, wrapping modulo 256.

## Operation
- Command accept: a command is written to the FIFO on any edge where `keyValid && keyReady`. When the FIFO is full, `keyValid` is ignored and nothing is dropped silently, because `keyReady` is already low.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE: when the FIFO is non-empty, pop the head into `curRow`/`curCol` and go to BOUNCE_IN. If `BOUNCE_TOGGLES==0`, go to HOLD instead.
- BOUNCE_IN:
  - Lasts 2*`BOUNCE_TOGGLES` periods of `BOUNCE_CYCLES` cycles each.
  - `contact`=1 in even periods (0,2,…) and 0 in odd periods.
  - Then go to HOLD.
- HOLD: `contact`=1 for `HOLD_CYCLES` cycles. `pressCount` increments on the edge that enters HOLD. Then go to BOUNCE_OUT, or to GAP when bounce is disabled.
- BOUNCE_OUT: same period structure as BOUNCE_IN, with `contact`=0 in even periods and 1 in odd periods. Then go to GAP.
- GAP: `contact`=0 for `GAP_CYCLES` cycles, then go to IDLE. A queued command is popped on the first IDLE cycle.
- Row response: the only combinational path in the block is `colPins`→`rowPins`.
  - `rowPins[curRow]` = 0 iff `contact`=1 and `colPins[curCol]`=0.
  - All other `rowPins` bits = 1.
  - Several columns driven low at once are handled correctly: only the selected column matters.
- Only one key is ever pressed at a time; multi-key presses are not modelled.
- One shared down-counter, wide enough for max(`HOLD_CYCLES`, `GAP_CYCLES`, `BOUNCE_CYCLES`), is reloaded on every state or period entry.
- A separate period counter of width clog2(2*`BOUNCE_TOGGLES`+1) tracks bounce periods.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `contact`=0, so `rowPins`=4'b1111 regardless of `colPins`.
  - `keyReady`=1, `busy`=0, `pressCount`=0.
- Latency: a command captured at edge N when the FIFO is empty and the FSM is IDLE gives `contact`=1 after edge N+1. `busy` rises after edge N.
- Total press duration with bounce: 2·`BOUNCE_TOGGLES`·`BOUNCE_CYCLES` + `HOLD_CYCLES` + 2·`BOUNCE_TOGGLES`·`BOUNCE_CYCLES` + `GAP_CYCLES` cycles in non-IDLE states, plus 1 IDLE cycle before the next pop.
- Simultaneous push and pop on the same edge when the FIFO is full: `keyReady` is already low, so no push occurs. When the FIFO is non-full, both push and pop happen and the count is unchanged.
- `keyReady` deasserts on the edge where the FIFO count reaches `QUEUE_DEPTH`. It reasserts on the edge of the next pop.
- Reset mid-press: `rowPins` returns to all ones immediately (asynchronously), and the FIFO contents are discarded.
- `pressCount` wraps from 255 to 0 without any flag.
- `keyCode` is sampled only at accept. Changes afterwards have no effect.

## Test plan
All scenarios use `HOLD_CYCLES`=20, `GAP_CYCLES`=10, `BOUNCE_CYCLES`=3, `BOUNCE_TOGGLES`=2.

1. Reset: assert `reset` with `colPins`=4'b0000 -> `rowPins`=4'b1111, `keyReady`=1, `busy`=0, `pressCount`=0.
2. Single press of `keyCode`=4'b0110 (row 1, col 2), with `colPins` held at 4'b1011 ->
   - `rowPins[1]` pattern: low 3, high 3, low 3, high 3, low 20, then high 3, low 3, high 3, low 3, high 10.
   - All other rows stay high.
   - `pressCount`=1.
3. Scan response during HOLD of the same key, with `colPins` rotating 1110→1101→1011→0111 per cycle -> `rowPins`=4'b1101 only while `colPins`=4'b1011, else 4'b1111, with the same-cycle response.
4. FIFO fill: push 5 commands back-to-back while busy -> `keyReady` low after the 4th accept. All 5 commands are eventually pressed in order, and `pressCount`=5 at the end.
5. `BOUNCE_TOGGLES`=0, `keyCode`=4'b1111 with `colPins`=4'b0111 -> `rowPins`=4'b0111 for exactly 20 cycles starting 2 edges after accept, with no glitches.
6. Assert `reset` during HOLD with 2 commands queued -> `rowPins`=4'b1111 immediately, `busy`=0 after reset, and no further presses occur.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad responder that plays queued key presses onto the row lines
module keypad_emulator #(
    parameter int HOLD_CYCLES    = 2000,
    parameter int GAP_CYCLES     = 2000,
    parameter int BOUNCE_CYCLES  = 64,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyValid,
    input  logic [3:0] keyCode,
    output logic       keyReady,
    input  logic [3:0] colPins,
    output logic [3:0] rowPins,
    output logic       busy,
    output logic [7:0] pressCount
);
    localparam int MAX_C = (HOLD_CYCLES > GAP_CYCLES) ?
                           ((HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES) :
                           ((GAP_CYCLES > BOUNCE_CYCLES) ? GAP_CYCLES : BOUNCE_CYCLES);
    localparam int CW = $clog2(MAX_C + 1);
    localparam int PW = (BOUNCE_TOGGLES == 0) ? 1 : $clog2(2 * BOUNCE_TOGGLES + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BNC_LD   = CW'(BOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST = PW'((BOUNCE_TOGGLES == 0) ? 0 : 2 * BOUNCE_TOGGLES - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(QUEUE_DEPTH);

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] per;
    logic          contact;
    logic [1:0]    cur_row;
    logic [1:0]    cur_col;
    logic [3:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign keyReady = count != FULL;
    assign push     = keyValid && keyReady;
    assign pop      = state == IDLE && count != '0;
    assign busy     = state != IDLE || count != '0;

    // command storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= keyCode;
    end

    // FIFO pointers and occupancy; a push and pop on the same edge leave count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // press sequencer: one shared down-counter reloaded on every state or bounce-period entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            per        <= '0;
            contact    <= 1'b0;
            cur_row    <= 2'd0;
            cur_col    <= 2'd0;
            pressCount <= 8'd0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {cur_row, cur_col} <= mem[rd_ptr];
                    per     <= '0;
                    contact <= 1'b1;
                    if (BOUNCE_TOGGLES == 0) begin
                        state      <= HOLD;
                        cnt        <= HOLD_LD;
                        pressCount <= pressCount + 8'd1;
                    end else begin
                        state <= BOUNCE_IN;
                        cnt   <= BNC_LD;
                    end
                end
                BOUNCE_IN: if (cnt != '0) cnt <= cnt - CW'(1);
                else if (per == PER_LAST) begin
                    state      <= HOLD;
                    cnt        <= HOLD_LD;
                    contact    <= 1'b1;
                    pressCount <= pressCount + 8'd1;
                end else begin
                    per     <= per + PW'(1);
                    cnt     <= BNC_LD;
                    contact <= ~contact;
                end
                HOLD: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    state   <= (BOUNCE_TOGGLES == 0) ? GAP : BOUNCE_OUT;
                    cnt     <= (BOUNCE_TOGGLES == 0) ? GAP_LD : BNC_LD;
                    per     <= '0;
                    contact <= 1'b0;
                end
                BOUNCE_OUT: if (cnt != '0) cnt <= cnt - CW'(1);
                else if (per == PER_LAST) begin
                    state   <= GAP;
                    cnt     <= GAP_LD;
                    contact <= 1'b0;
                end else begin
                    per     <= per + PW'(1);
                    cnt     <= BNC_LD;
                    contact <= ~contact;
                end
                GAP: if (cnt != '0) cnt <= cnt - CW'(1);
                else state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // the pressed key shorts its row to its column only while that column is driven low
    always_comb begin
        rowPins          = 4'b1111;
        rowPins[cur_row] = !(contact && !colPins[cur_col]);
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized check of two keypad emulators (with and without bounce) against a timeline model
module tb_keypad_emulator;
    logic       clk;
    logic       reset;
    logic       kv [2];
    logic [3:0] kc [2];
    logic [3:0] cp [2];
    logic [3:0] row [2];
    logic       rdy [2];
    logic       bsy [2];
    logic [7:0] pcnt [2];

    int checks = 0;
    int errors = 0;

    int qm [2][16];
    int qn [2];
    bit act [2];
    int t [2];
    int cur [2];
    int pc [2];
    int btv [2];
    int cp_mode [2];
    logic [3:0] cp_set [2];
    int low5 = 0;

    keypad_emulator #(.HOLD_CYCLES(20), .GAP_CYCLES(10), .BOUNCE_CYCLES(3), .BOUNCE_TOGGLES(2), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .keyValid(kv[0]), .keyCode(kc[0]), .keyReady(rdy[0]),
        .colPins(cp[0]), .rowPins(row[0]), .busy(bsy[0]), .pressCount(pcnt[0]));

    keypad_emulator #(.HOLD_CYCLES(20), .GAP_CYCLES(10), .BOUNCE_CYCLES(3), .BOUNCE_TOGGLES(0), .QUEUE_DEPTH(4)) dut_nb (
        .clk(clk), .reset(reset), .keyValid(kv[1]), .keyCode(kc[1]), .keyReady(rdy[1]),
        .colPins(cp[1]), .rowPins(row[1]), .busy(bsy[1]), .pressCount(pcnt[1]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bi(input int i);
        return 2 * btv[i] * 3;
    endfunction

    // contact as a function of time since the pop edge: bounce-in, hold, bounce-out, gap
    function automatic bit contact_f(input int i);
        if (!act[i]) return 0;
        if (t[i] < bi(i)) return ((t[i] / 3) % 2) == 0;
        if (t[i] < bi(i) + 20) return 1;
        if (t[i] < 2 * bi(i) + 20) return ((t[i] - bi(i) - 20) / 3) % 2 == 1;
        return 0;
    endfunction

    function automatic logic [3:0] row_f(input int i);
        logic [3:0] r = 4'hf;
        if (contact_f(i) && !cp[i][cur[i] % 4]) r[cur[i] / 4] = 1'b0;
        return r;
    endfunction

    task automatic upd(input int i);
        bit acc = kv[i] && qn[i] < 4;
        if (act[i]) begin
            t[i]++;
            if (t[i] == 2 * bi(i) + 30) act[i] = 0;
        end else if (qn[i] > 0) begin
            cur[i] = qm[i][0];
            for (int k = 0; k < 15; k++) qm[i][k] = qm[i][k + 1];
            qn[i]--;
            act[i] = 1;
            t[i] = 0;
        end
        if (act[i] && t[i] == bi(i)) pc[i] = (pc[i] + 1) % 256;
        if (acc) begin
            qm[i][qn[i]] = int'(kc[i]);
            qn[i]++;
        end
    endtask

    initial begin
        btv[0] = 2;
        btv[1] = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    qn[i] = 0;
                    act[i] = 0;
                    t[i] = 0;
                    pc[i] = 0;
                end
            end else begin
                upd(0);
                upd(1);
            end
        end
    end

    initial begin
        cp[0] = 4'hf;
        cp[1] = 4'hf;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                cp[i] = (cp_mode[i] == 1) ? {cp[i][2:0], cp[i][3]} :
                        (cp_mode[i] == 2) ? 4'($urandom) : cp_set[i];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("row%0d", i), int'(row[i]), int'(row_f(i)));
                chk($sformatf("ready%0d", i), int'(rdy[i]), int'(qn[i] < 4));
                chk($sformatf("busy%0d", i), int'(bsy[i]), int'(act[i] || qn[i] > 0));
                chk($sformatf("count%0d", i), int'(pcnt[i]), pc[i]);
            end
            if (row[1] == 4'b0111) low5++;
        end
    end

    task automatic push(input int i, input logic [3:0] code);
        bit r;
        int n = 0;
        kv[i] = 1;
        kc[i] = code;
        do begin
            @(negedge clk);
            r = rdy[i];
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 3000);
        kv[i] = 0;
        kc[i] = ~code;
        if (!r) chk("push_timeout", int'(rdy[i]), 1);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (bsy[i] && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", int'(bsy[i]), 0);
    endtask

    initial begin
        int n;
        reset = 1;
        kv[0] = 0;
        kv[1] = 0;
        kc[0] = 0;
        kc[1] = 0;
        cp_mode[0] = 0;
        cp_mode[1] = 0;
        cp_set[0] = 4'b0000;
        cp_set[1] = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_row", int'(row[0]), 15);
        reset = 0;

        cp_set[0] = 4'b1011;
        repeat (2) @(posedge clk);
        #1;
        push(0, 4'b0110);
        wait_idle(0);
        chk("single_press", int'(pcnt[0]), 1);

        cp_set[0] = 4'b1110;
        repeat (2) @(posedge clk);
        #1;
        cp_mode[0] = 1;
        push(0, 4'b0110);
        wait_idle(0);
        cp_mode[0] = 0;
        chk("scan_press", int'(pcnt[0]), 2);

        cp_mode[0] = 2;
        for (int k = 0; k < 5; k++) push(0, 4'($urandom));
        wait_idle(0);
        chk("fifo_fill", int'(pcnt[0]), 7);

        cp_set[1] = 4'b0111;
        repeat (2) @(posedge clk);
        #1;
        low5 = 0;
        push(1, 4'b1111);
        wait_idle(1);
        chk("nobounce_low", low5, 20);
        chk("nobounce_press", int'(pcnt[1]), 1);

        cp_mode[0] = 0;
        cp_set[0] = 4'b0000;
        for (int k = 0; k < 3; k++) push(0, 4'($urandom));
        n = 0;
        while (!(act[0] && t[0] == bi(0) + 5) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_reached", int'(act[0]), 1);
        chk("hold_row_low", int'(row[0] != 4'hf), 1);
        reset = 1;
        #1;
        chk("reset_row_async", int'(row[0]), 15);
        @(posedge clk);
        #1;
        reset = 0;
        repeat (200) @(posedge clk);
        #1;
        chk("reset_busy", int'(bsy[0]), 0);
        chk("reset_no_press", int'(pcnt[0]), 0);

        cp_mode[0] = 2;
        cp_mode[1] = 2;
        for (int k = 0; k < 12; k++) begin
            push(int'($urandom_range(1, 0)), 4'($urandom));
            repeat ($urandom_range(15, 0)) @(posedge clk);
            #1;
        end
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge clk);
        #1;
        chk("random_done0", int'(bsy[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
